// File: rtl/nibble_ser_tx.sv
// -----------------------------------------------------------------------------
// nibble_ser_tx
//
// Frame serializer for the 4-bit nibble lane. A NIBBLES*4-bit word is captured
// on accept and sent most-significant nibble first. tx_sof marks nibble 0 and
// tx_eof marks nibble NIBBLES-1. After each end-of-frame the lane is held idle
// for IDLE_GAP cycles before the next word can be accepted. X/Z bits in the
// captured word reach the lane unmodified.
//
// Parameters:
//   NIBBLES   nibbles per frame (>=1); the word width is NIBBLES*4
//   IDLE_GAP  forced idle cycles after each end-of-frame (>=0)
//
// Optional feature macro:
//   NIBBLE_TX_PARITY_EN  when defined, tx_par carries odd parity over
//                        {tx_par, tx_nib} while tx_valid=1; when undefined,
//                        tx_par is tied to 0 and no parity logic is built.
//
// Ports:
//   clk       in   single clock, all logic on the rising edge
//   rst       in   synchronous, active-high reset
//   in_word   in   word to send (NIBBLES*4 bits), sampled only on accept
//   in_valid  in   in_word is valid
//   in_ready  out  block can accept a word (IDLE state, not in reset)
//   tx_nib    out  current nibble
//   tx_sof    out  current nibble is nibble 0
//   tx_eof    out  current nibble is nibble NIBBLES-1
//   tx_valid  out  lane outputs valid
//   tx_ready  in   downstream accepts the current nibble
//   tx_par    out  parity of tx_nib (see macro above)
//   busy      out  state is not IDLE
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. On the input side this is in_valid && in_ready; on the lane side it
// is tx_valid && tx_ready. Once tx_valid is raised it stays high, and the lane
// outputs stay stable, until the nibble is taken. in_valid outside IDLE is
// ignored and never captured.
//
// Every lane output is decoded from registered state only; neither tx_ready
// nor in_valid reaches an output combinationally. The internal FSM state is
// the r_state register (type state_t) for hierarchical inspection.
// -----------------------------------------------------------------------------
module nibble_ser_tx #(
    parameter int NIBBLES  = 5,
    parameter int IDLE_GAP = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NIBBLES*4-1:0] in_word,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [3:0]           tx_nib,
    output logic                 tx_sof,
    output logic                 tx_eof,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 tx_par,
    output logic                 busy
);

    // -------------------------------------------------------------------------
    // Local sizing
    // -------------------------------------------------------------------------
    localparam int W  = NIBBLES * 4;
    // Counters are at least one bit wide so NIBBLES=1 / IDLE_GAP<=1 still
    // elaborate with a legal vector.
    localparam int CW = (NIBBLES > 1)  ? $clog2(NIBBLES)  : 1;
    localparam int GW = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(NIBBLES - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((IDLE_GAP > 0) ? (IDLE_GAP - 1) : 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Registers and internal wires
    // -------------------------------------------------------------------------
    state_t          r_state;
    logic [W-1:0]    r_sh;      // outgoing nibbles, current one at the top
    logic [CW-1:0]   r_cnt;     // index of the nibble currently on the lane
    logic [GW-1:0]   r_gcnt;    // idle cycles already spent in GAP

    state_t          w_state_nxt;
    logic            w_last;    // current nibble is the eof nibble
    logic            w_fire;    // lane handshake completes this edge

    assign w_last = (r_cnt == CNT_LAST);
    assign w_fire = (r_state == ST_SEND) && tx_ready;

    // -------------------------------------------------------------------------
    // FSM process 1: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM process 2: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                // in_ready is 1 throughout IDLE outside reset, and reset
                // overrides this transition in the state register.
                if (in_valid) begin
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (w_fire && w_last) begin
                    // With no gap configured the next word may be accepted
                    // in the cycle straight after the eof nibble.
                    w_state_nxt = (IDLE_GAP == 0) ? ST_IDLE : ST_GAP;
                end
            end
            ST_GAP: begin
                if (r_gcnt == GAP_LAST) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM process 3: output decode (registered state only, plus reset gating
    // of in_ready so nothing is accepted while rst is high)
    // -------------------------------------------------------------------------
    always_comb begin
        in_ready = (r_state == ST_IDLE) && !rst;
        busy     = (r_state != ST_IDLE);
        tx_valid = (r_state == ST_SEND);
        // The shift register always drives the lane; the value is only
        // meaningful while tx_valid=1.
        tx_nib   = r_sh[W-1 -: 4];
        tx_sof   = tx_valid && (r_cnt == '0);
        tx_eof   = tx_valid && w_last;
`ifdef NIBBLE_TX_PARITY_EN
        // XNOR-reduce gives odd parity across the nibble and the parity bit.
        tx_par   = tx_valid && ~(^tx_nib);
`else
        tx_par   = 1'b0;
`endif
    end

    // -------------------------------------------------------------------------
    // Datapath: shift register, nibble counter, gap counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh   <= '0;
            r_cnt  <= '0;
            r_gcnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_sh  <= in_word;
                        r_cnt <= '0;
                    end
                end
                ST_SEND: begin
                    // Nothing moves while the lane is stalled, which keeps
                    // tx_nib/sof/eof/par stable under backpressure.
                    if (w_fire) begin
                        r_sh  <= r_sh << 4;
                        r_cnt <= r_cnt + CW'(1);
                        if (w_last) begin
                            r_gcnt <= '0;
                        end
                    end
                end
                ST_GAP: begin
                    r_gcnt <= r_gcnt + GW'(1);
                end
                default: begin
                    r_sh   <= r_sh;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_ser_tx.sv
// -----------------------------------------------------------------------------
// tb_nibble_ser_tx
//
// Directed bench for nibble_ser_tx. The main instance uses the default
// configuration (NIBBLES=5, IDLE_GAP=1) and is driven from a per-cycle table
// of inputs and hand-computed expected outputs. A second instance with
// NIBBLES=1, IDLE_GAP=0 is exercised by a short hand-written sequence.
// Row n of the table is one clock cycle: its inputs are applied just after
// the rising edge that starts the cycle and outputs are sampled on the
// falling edge in the middle of it.
// -----------------------------------------------------------------------------
module tb_nibble_ser_tx;

    // -------------------------------------------------------------------------
    // Clock / reset
    // -------------------------------------------------------------------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;

    // Main instance (NIBBLES=5, IDLE_GAP=1)
    logic [19:0] in_word;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  tx_nib;
    logic        tx_sof;
    logic        tx_eof;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_par;
    logic        busy;

    // Single-nibble instance (NIBBLES=1, IDLE_GAP=0)
    logic [3:0]  in_word1;
    logic        in_valid1;
    logic        in_ready1;
    logic [3:0]  tx_nib1;
    logic        tx_sof1;
    logic        tx_eof1;
    logic        tx_valid1;
    logic        tx_ready1;
    logic        tx_par1;
    logic        busy1;

    nibble_ser_tx #(.NIBBLES(5), .IDLE_GAP(1)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .in_word  (in_word),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .tx_nib   (tx_nib),
        .tx_sof   (tx_sof),
        .tx_eof   (tx_eof),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_par   (tx_par),
        .busy     (busy)
    );

    nibble_ser_tx #(.NIBBLES(1), .IDLE_GAP(0)) u_dut1 (
        .clk      (clk),
        .rst      (rst),
        .in_word  (in_word1),
        .in_valid (in_valid1),
        .in_ready (in_ready1),
        .tx_nib   (tx_nib1),
        .tx_sof   (tx_sof1),
        .tx_eof   (tx_eof1),
        .tx_valid (tx_valid1),
        .tx_ready (tx_ready1),
        .tx_par   (tx_par1),
        .busy     (busy1)
    );

    // -------------------------------------------------------------------------
    // Vector table
    // -------------------------------------------------------------------------
    typedef struct {
        logic        rst;
        logic        iv;
        logic [19:0] w;
        logic        tr;
        logic        rdy;
        logic        bsy;
        logic        v;
        logic [3:0]  nib;
        logic        sof;
        logic        eof;
        logic        p;    // parity expected when the parity feature is built
        logic        cn;   // compare tx_nib in this row
    } vec_t;

    vec_t tbl[$];

    int errors = 0;
    int checks = 0;

    task automatic add(input logic r, input logic iv, input logic [19:0] w,
                       input logic tr, input logic rdy, input logic bsy,
                       input logic v, input logic [3:0] nib, input logic sof,
                       input logic eof, input logic p, input logic cn);
        vec_t e;
        e.rst = r;   e.iv = iv;   e.w = w;     e.tr = tr;
        e.rdy = rdy; e.bsy = bsy; e.v = v;     e.nib = nib;
        e.sof = sof; e.eof = eof; e.p = p;     e.cn = cn;
        tbl.push_back(e);
    endtask

    function automatic logic exp_par(input logic p);
`ifdef NIBBLE_TX_PARITY_EN
        return p;
`else
        return 1'b0 & p;
`endif
    endfunction

    // -------------------------------------------------------------------------
    // Scoreboard compare
    // -------------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check1(input string tag, input logic rdy, input logic bsy,
                          input logic v, input logic [3:0] nib,
                          input logic sof, input logic eof, input logic p);
        check({tag, " in_ready"}, 32'(in_ready1), 32'(rdy));
        check({tag, " busy"},     32'(busy1),     32'(bsy));
        check({tag, " tx_valid"}, 32'(tx_valid1), 32'(v));
        check({tag, " tx_sof"},   32'(tx_sof1),   32'(sof));
        check({tag, " tx_eof"},   32'(tx_eof1),   32'(eof));
        check({tag, " tx_par"},   32'(tx_par1),   32'(exp_par(p)));
        if (v) begin
            check({tag, " tx_nib"}, 32'(tx_nib1), 32'(nib));
        end
    endtask

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_word   = '0;
        tx_ready  = 1'b1;
        in_valid1 = 1'b0;
        in_word1  = '0;
        tx_ready1 = 1'b1;

        //   rst iv word      tr  rdy bsy v  nib  sof eof p  cn
        // Reset state, then first cycle after rst falls
        add(1, 0, 20'h0,     1,  0,  0,  0, 4'h0, 0, 0, 0, 1);
        add(0, 0, 20'h0,     1,  1,  0,  0, 4'h0, 0, 0, 0, 1);
        // Basic frame, tx_ready=1
        add(0, 1, 20'hA5C3E, 1,  1,  0,  0, 4'h0, 0, 0, 0, 0);
        add(0, 0, 20'h0,     1,  0,  1,  1, 4'hA, 1, 0, 1, 1);
        add(0, 0, 20'h0,     1,  0,  1,  1, 4'h5, 0, 0, 1, 1);
        add(0, 0, 20'h0,     1,  0,  1,  1, 4'hC, 0, 0, 1, 1);
        add(0, 0, 20'h0,     1,  0,  1,  1, 4'h3, 0, 0, 1, 1);
        add(0, 0, 20'h0,     1,  0,  1,  1, 4'hE, 0, 1, 0, 1);
        add(0, 0, 20'h0,     1,  0,  1,  0, 4'h0, 0, 0, 0, 0);
        add(0, 0, 20'h0,     1,  1,  0,  0, 4'h0, 0, 0, 0, 0);
        // Backpressure: tx_ready=0 in cycles 3..5
        add(0, 1, 20'hA5C3E, 1,  1,  0,  0, 4'h0, 0, 0, 0, 0);
        add(0, 0, 20'h0,     1,  0,  1,  1, 4'hA, 1, 0, 1, 1);
        add(0, 0, 20'h0,     1,  0,  1,  1, 4'h5, 0, 0, 1, 1);
        add(0, 0, 20'h0,     0,  0,  1,  1, 4'hC, 0, 0, 1, 1);
        add(0, 0, 20'h0,     0,  0,  1,  1, 4'hC, 0, 0, 1, 1);
        add(0, 0, 20'h0,     0,  0,  1,  1, 4'hC, 0, 0, 1, 1);
        add(0, 0, 20'h0,     1,  0,  1,  1, 4'hC, 0, 0, 1, 1);
        add(0, 0, 20'h0,     1,  0,  1,  1, 4'h3, 0, 0, 1, 1);
        add(0, 0, 20'h0,     1,  0,  1,  1, 4'hE, 0, 1, 0, 1);
        add(0, 0, 20'h0,     1,  0,  1,  0, 4'h0, 0, 0, 0, 0);
        add(0, 0, 20'h0,     1,  1,  0,  0, 4'h0, 0, 0, 0, 0);
        // in_valid held high: second word ignored until IDLE (cycle 7)
        add(0, 1, 20'h12345, 1,  1,  0,  0, 4'h0, 0, 0, 0, 0);
        add(0, 1, 20'h6789A, 1,  0,  1,  1, 4'h1, 1, 0, 0, 1);
        add(0, 1, 20'h6789A, 1,  0,  1,  1, 4'h2, 0, 0, 0, 1);
        add(0, 1, 20'h6789A, 1,  0,  1,  1, 4'h3, 0, 0, 1, 1);
        add(0, 1, 20'h6789A, 1,  0,  1,  1, 4'h4, 0, 0, 0, 1);
        add(0, 1, 20'h6789A, 1,  0,  1,  1, 4'h5, 0, 1, 1, 1);
        add(0, 1, 20'h6789A, 1,  0,  1,  0, 4'h0, 0, 0, 0, 0);
        add(0, 1, 20'h6789A, 1,  1,  0,  0, 4'h0, 0, 0, 0, 0);
        add(0, 0, 20'h0,     1,  0,  1,  1, 4'h6, 1, 0, 1, 1);
        add(0, 0, 20'h0,     1,  0,  1,  1, 4'h7, 0, 0, 0, 1);
        add(0, 0, 20'h0,     1,  0,  1,  1, 4'h8, 0, 0, 0, 1);
        add(0, 0, 20'h0,     1,  0,  1,  1, 4'h9, 0, 0, 1, 1);
        add(0, 0, 20'h0,     1,  0,  1,  1, 4'hA, 0, 1, 1, 1);
        add(0, 0, 20'h0,     1,  0,  1,  0, 4'h0, 0, 0, 0, 0);
        add(0, 0, 20'h0,     1,  1,  0,  0, 4'h0, 0, 0, 0, 0);
        // Reset mid-frame in cycle 3, then a fresh frame (parity word)
        add(0, 1, 20'hA5C3E, 1,  1,  0,  0, 4'h0, 0, 0, 0, 0);
        add(0, 0, 20'h0,     1,  0,  1,  1, 4'hA, 1, 0, 1, 1);
        add(0, 0, 20'h0,     1,  0,  1,  1, 4'h5, 0, 0, 1, 1);
        add(1, 0, 20'h0,     1,  0,  1,  1, 4'hC, 0, 0, 1, 1);
        add(0, 0, 20'h0,     1,  1,  0,  0, 4'h0, 0, 0, 0, 1);
        add(0, 0, 20'h0,     1,  1,  0,  0, 4'h0, 0, 0, 0, 0);
        add(0, 1, 20'h73F00, 1,  1,  0,  0, 4'h0, 0, 0, 0, 0);
        add(0, 0, 20'h0,     1,  0,  1,  1, 4'h7, 1, 0, 0, 1);
        add(0, 0, 20'h0,     1,  0,  1,  1, 4'h3, 0, 0, 1, 1);
        add(0, 0, 20'h0,     1,  0,  1,  1, 4'hF, 0, 0, 1, 1);
        add(0, 0, 20'h0,     1,  0,  1,  1, 4'h0, 0, 0, 1, 1);
        add(0, 0, 20'h0,     1,  0,  1,  1, 4'h0, 0, 1, 1, 1);
        add(0, 0, 20'h0,     1,  0,  1,  0, 4'h0, 0, 0, 0, 0);
        add(0, 0, 20'h0,     1,  1,  0,  0, 4'h0, 0, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk);
            #1;
            rst      = tbl[i].rst;
            in_valid = tbl[i].iv;
            in_word  = tbl[i].w;
            tx_ready = tbl[i].tr;
            @(negedge clk);
            check($sformatf("row%0d in_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
            check($sformatf("row%0d busy", i),     32'(busy),     32'(tbl[i].bsy));
            check($sformatf("row%0d tx_valid", i), 32'(tx_valid), 32'(tbl[i].v));
            check($sformatf("row%0d tx_sof", i),   32'(tx_sof),   32'(tbl[i].sof));
            check($sformatf("row%0d tx_eof", i),   32'(tx_eof),   32'(tbl[i].eof));
            check($sformatf("row%0d tx_par", i),   32'(tx_par),   32'(exp_par(tbl[i].p)));
            if (tbl[i].cn) begin
                check($sformatf("row%0d tx_nib", i), 32'(tx_nib), 32'(tbl[i].nib));
            end
        end

        // Single-nibble instance: sof and eof on the same nibble, no gap
        @(posedge clk);
        #1;
        in_valid1 = 1'b1;
        in_word1  = 4'h9;
        tx_ready1 = 1'b1;
        @(negedge clk);
        check1("n1 c0", 1, 0, 0, 4'h0, 0, 0, 0);

        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        in_word1  = 4'h0;
        @(negedge clk);
        check1("n1 c1", 0, 1, 1, 4'h9, 1, 1, 1);

        @(posedge clk);
        #1;
        in_valid1 = 1'b1;
        in_word1  = 4'h5;
        @(negedge clk);
        check1("n1 c2", 1, 0, 0, 4'h0, 0, 0, 0);

        // Stall the single nibble; a word offered during SEND is ignored
        @(posedge clk);
        #1;
        in_valid1 = 1'b1;
        in_word1  = 4'hA;
        tx_ready1 = 1'b0;
        @(negedge clk);
        check1("n1 c3", 0, 1, 1, 4'h5, 1, 1, 1);

        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        in_word1  = 4'h0;
        tx_ready1 = 1'b1;
        @(negedge clk);
        check1("n1 c4", 0, 1, 1, 4'h5, 1, 1, 1);

        @(posedge clk);
        #1;
        @(negedge clk);
        check1("n1 c5", 1, 0, 0, 4'h0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
